// File: rtl/hazard_stall_unit.sv
// ============================================================================
// hazard_stall_unit : ID-stage hazard detector and multi-cycle stall sequencer.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
  parameter int LD_BR_STALLS = 2,
  parameter int PERF_W       = 32
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] IFID_Instr,
  input  logic        IDEX_MemRead,
  input  logic        IDEX_RegWrite,
  input  logic [4:0]  IDEX_DestReg,
  input  logic        EXMEM_MemRead,
  input  logic [4:0]  EXMEM_DestReg,
  input  logic        ID_BranchOrJR,
  input  logic        ID_Redirect,
  output logic        ControlMux,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        StallActive
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] StallCycles,
  output logic [PERF_W-1:0] FlushCount
`endif
);

  // Out-of-range settings are clamped so the 2-bit hold counter stays valid.
  localparam int         c_ld_br_int = (LD_BR_STALLS < 1) ? 1 :
                                       (LD_BR_STALLS > 3) ? 3 : LD_BR_STALLS;
  localparam logic [1:0] c_ld_br_n   = c_ld_br_int[1:0];

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_rem, w_rem_nxt;

  logic [5:0] w_op, w_funct;
  logic [4:0] w_rs, w_rt;
  logic       w_use_rs, w_use_rt;
  logic       w_match_ex, w_match_mem;
  logic       w_h_lu, w_h_bl, w_h_ba, w_h_bm;
  logic [1:0] w_n;
  logic       w_ctrl, w_pcw, w_ifidw, w_flush, w_stall_active;
  logic       w_unused_instr;

  assign w_op    = IFID_Instr[31:26];
  assign w_rs    = IFID_Instr[25:21];
  assign w_rt    = IFID_Instr[20:16];
  assign w_funct = IFID_Instr[5:0];
  assign w_unused_instr = ^IFID_Instr[15:6];

  always_comb begin
    w_use_rt = 1'b0;
    case (w_op)
      6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: w_use_rt = 1'b1;
      default:                                  w_use_rt = 1'b0;
    endcase
  end

  // Jumps, lui and constant shifts carry no rs operand.
  always_comb begin
    w_use_rs = 1'b1;
    case (w_op)
      6'h02, 6'h03, 6'h0F: w_use_rs = 1'b0;
      6'h00: w_use_rs = !((w_funct == 6'h00) || (w_funct == 6'h02) || (w_funct == 6'h03));
      default: w_use_rs = 1'b1;
    endcase
  end

  assign w_match_ex  = (IDEX_DestReg != 5'd0) &&
                       ((w_use_rs && (w_rs == IDEX_DestReg)) ||
                        (w_use_rt && (w_rt == IDEX_DestReg)));
  assign w_match_mem = (EXMEM_DestReg != 5'd0) &&
                       ((w_use_rs && (w_rs == EXMEM_DestReg)) ||
                        (w_use_rt && (w_rt == EXMEM_DestReg)));

  assign w_h_lu = IDEX_MemRead && w_match_ex;
  assign w_h_bl = ID_BranchOrJR && IDEX_MemRead && w_match_ex;
  assign w_h_ba = ID_BranchOrJR && IDEX_RegWrite && !IDEX_MemRead && w_match_ex;
  assign w_h_bm = ID_BranchOrJR && EXMEM_MemRead && w_match_mem;

  assign w_n = w_h_bl                      ? c_ld_br_n :
               (w_h_lu || w_h_ba || w_h_bm) ? 2'd1      : 2'd0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_RUN;
      r_rem   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rem_nxt      = r_rem;
    w_ctrl         = 1'b1;
    w_pcw          = 1'b1;
    w_ifidw        = 1'b1;
    w_flush        = 1'b0;
    w_stall_active = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_n != 2'd0) begin
          // An unresolved branch cannot redirect, so no flush while bubbling.
          w_ctrl  = 1'b0;
          w_pcw   = 1'b0;
          w_ifidw = 1'b0;
          if (w_n >= 2'd2) begin
            w_rem_nxt   = w_n - 2'd1;
            w_state_nxt = ST_STALL;
          end
        end else begin
          w_flush = ID_Redirect;
        end
      end
      ST_STALL: begin
        w_ctrl         = 1'b0;
        w_pcw          = 1'b0;
        w_ifidw        = 1'b0;
        w_stall_active = 1'b1;
        w_rem_nxt      = r_rem - 2'd1;
        if (r_rem <= 2'd1) begin
          w_rem_nxt   = 2'd0;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_rem_nxt   = 2'd0;
      end
    endcase
  end

  // Reset overrides the decision immediately, even mid-hold.
  assign ControlMux  = !Rst_n || w_ctrl;
  assign PCWrite     = !Rst_n || w_pcw;
  assign IFIDWrite   = !Rst_n || w_ifidw;
  assign IFIDFlush   = Rst_n && w_flush;
  assign StallActive = Rst_n && w_stall_active;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cycles, r_flush_count;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!ControlMux && (r_stall_cycles != {PERF_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (IFIDFlush && (r_flush_count != {PERF_W{1'b1}}))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign StallCycles = r_stall_cycles;
  assign FlushCount  = r_flush_count;
`else
  localparam int c_unused_perf_w = PERF_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// tb_hazard_stall_unit : directed self-checking bench for hazard_stall_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] IFID_Instr;
  logic        IDEX_MemRead;
  logic        IDEX_RegWrite;
  logic [4:0]  IDEX_DestReg;
  logic        EXMEM_MemRead;
  logic [4:0]  EXMEM_DestReg;
  logic        ID_BranchOrJR;
  logic        ID_Redirect;
  logic        ControlMux;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        StallActive;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [31:0] FlushCount;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // {ControlMux, PCWrite, IFIDWrite, IFIDFlush, StallActive}
  localparam logic [4:0] c_pass   = 5'b11100;
  localparam logic [4:0] c_flush  = 5'b11110;
  localparam logic [4:0] c_bubble = 5'b00000;
  localparam logic [4:0] c_hold   = 5'b00001;

  localparam logic [31:0] c_add_9_8_10 = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] c_add_2_0_4  = {6'h00, 5'd0, 5'd4, 5'd2, 5'd0, 6'h20};
  localparam logic [31:0] c_add_3_0_0  = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] c_add_1_9_0  = {6'h00, 5'd9, 5'd0, 5'd1, 5'd0, 6'h20};
  localparam logic [31:0] c_beq_5_6    = {6'h04, 5'd5, 5'd6, 16'h0000};
  localparam logic [31:0] c_beq_9_0    = {6'h04, 5'd9, 5'd0, 16'h0000};
  localparam logic [31:0] c_bne_7_0    = {6'h05, 5'd7, 5'd0, 16'h0000};
  localparam logic [31:0] c_sll_2_4_3  = {6'h00, 5'd4, 5'd0, 5'd2, 5'd3, 6'h00};
  localparam logic [31:0] c_lui_4      = {6'h0F, 5'd4, 5'd4, 16'h1234};

  hazard_stall_unit #(
    .LD_BR_STALLS(2),
    .PERF_W      (32)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .IFID_Instr   (IFID_Instr),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_DestReg (IDEX_DestReg),
    .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_DestReg(EXMEM_DestReg),
    .ID_BranchOrJR(ID_BranchOrJR),
    .ID_Redirect  (ID_Redirect),
    .ControlMux   (ControlMux),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IFIDFlush    (IFIDFlush),
    .StallActive  (StallActive)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCycles  (StallCycles),
    .FlushCount   (FlushCount)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {ControlMux, PCWrite, IFIDWrite, IFIDFlush, StallActive};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    IFID_Instr    = 32'h0000_0000;
    IDEX_MemRead  = 1'b0;
    IDEX_RegWrite = 1'b0;
    IDEX_DestReg  = 5'd0;
    EXMEM_MemRead = 1'b0;
    EXMEM_DestReg = 5'd0;
    ID_BranchOrJR = 1'b0;
    ID_Redirect   = 1'b0;
  endtask

  task automatic set_ex_load(input logic [4:0] dest);
    IDEX_MemRead  = 1'b1;
    IDEX_RegWrite = 1'b1;
    IDEX_DestReg  = dest;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0;
    set_idle();
    // Reset dominates even with a load-use hazard present
    set_ex_load(5'd8);
    IFID_Instr = c_add_9_8_10;
    #2;
    check("reset_forced", c_pass);
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("reset_stall_cnt", StallCycles, 32'd0);
    check_cnt("reset_flush_cnt", FlushCount, 32'd0);
`endif
    tick();
    tick();
    set_idle();
    Rst_n = 1'b1;
    #1;
    check("idle_after_reset", c_pass);

    // Load-use: one bubble, then pass
    tick();
    set_ex_load(5'd8);
    IFID_Instr = c_add_9_8_10;
    #1;
    check("lu_bubble", c_bubble);
    tick();
    set_idle();
    IFID_Instr = c_add_9_8_10;
    #1;
    check("lu_release", c_pass);
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("lu_stall_cnt", StallCycles, 32'd1);
`endif

    // Load via rt operand also stalls
    tick();
    set_ex_load(5'd4);
    IFID_Instr = c_add_2_0_4;
    #1;
    check("lu_rt_bubble", c_bubble);

    // Branch after load: detect cycle, then one STALL cycle ignoring inputs
    tick();
    set_idle();
    set_ex_load(5'd5);
    IFID_Instr    = c_beq_5_6;
    ID_BranchOrJR = 1'b1;
    #1;
    check("bl_detect", c_bubble);
    tick();
    IFID_Instr    = $urandom();
    IDEX_MemRead  = 1'($urandom());
    IDEX_RegWrite = 1'($urandom());
    IDEX_DestReg  = 5'($urandom());
    EXMEM_MemRead = 1'($urandom());
    EXMEM_DestReg = 5'($urandom());
    ID_BranchOrJR = 1'($urandom());
    ID_Redirect   = 1'b1;
    #1;
    check("bl_hold", c_hold);
    tick();
    set_idle();
    IFID_Instr    = c_beq_5_6;
    ID_BranchOrJR = 1'b1;
    #1;
    check("bl_done", c_pass);

    // Branch after ALU: one bubble, then redirect flushes IF/ID
    tick();
    set_idle();
    IDEX_RegWrite = 1'b1;
    IDEX_DestReg  = 5'd7;
    IFID_Instr    = c_bne_7_0;
    ID_BranchOrJR = 1'b1;
    #1;
    check("ba_bubble", c_bubble);
    tick();
    IDEX_RegWrite = 1'b0;
    IDEX_DestReg  = 5'd0;
    ID_Redirect   = 1'b1;
    #1;
    check("ba_redirect", c_flush);
    tick();
    set_idle();
    #1;
    check("after_redirect", c_pass);

    // Register 0 and unused sources never match
    set_ex_load(5'd0);
    IFID_Instr = c_add_3_0_0;
    #1;
    check("r0_no_stall", c_pass);
    set_ex_load(5'd4);
    IFID_Instr = c_sll_2_4_3;
    #1;
    check("sll_rs_unused", c_pass);
    IFID_Instr = c_lui_4;
    #1;
    check("lui_no_stall", c_pass);

    // MEM-stage load only matters for branches
    tick();
    set_idle();
    EXMEM_MemRead = 1'b1;
    EXMEM_DestReg = 5'd9;
    IFID_Instr    = c_add_1_9_0;
    #1;
    check("mem_load_no_branch", c_pass);

    // Stall beats redirect
    IFID_Instr    = c_beq_9_0;
    ID_BranchOrJR = 1'b1;
    ID_Redirect   = 1'b1;
    #1;
    check("bm_beats_redirect", c_bubble);
    tick();
    set_idle();
    #1;
    check("bm_release", c_pass);

    // Reset in the middle of STALL
    tick();
    set_ex_load(5'd5);
    IFID_Instr    = c_beq_5_6;
    ID_BranchOrJR = 1'b1;
    tick();
    check("pre_reset_hold", c_hold);
    Rst_n = 1'b0;
    #1;
    check("reset_mid_stall", c_pass);
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("mid_reset_stall_cnt", StallCycles, 32'd0);
    check_cnt("mid_reset_flush_cnt", FlushCount, 32'd0);
`endif
    tick();
    Rst_n = 1'b1;
    #1;
    check("release_run_detect", c_bubble);
    tick();
    check("release_then_hold", c_hold);
    tick();
    set_idle();
    #1;
    check("resume_normal", c_pass);
    tick();
    check("resume_normal_2", c_pass);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage hazard detector and stall sequencer for the five-stage pipeline.
- Decides each cycle whether the decode-stage control bundle passes into ID/EX or is replaced by a bubble. It drives the bubble-select line consumed by the controller mux (1 = pass, 0 = bubble).
- Also freezes PC and IF/ID on stalls and flushes IF/ID on taken branches and jumps.
- A small FSM holds multi-cycle stalls for branch-after-load.

Parameters:
- LD_BR_STALLS, 2: bubbles inserted when an ID-stage branch/JR source is the destination of a load in EX; legal range 1..3.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- IFID_Instr  in  32  instruction in ID; rs=[25:21], rt=[20:16], op=[31:26], funct=[5:0].
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_RegWrite  in  1  instruction in EX writes the register file.
- IDEX_DestReg  in  5  destination register of the EX instruction (after RegDst).
- EXMEM_MemRead  in  1  instruction in MEM is a load.
- EXMEM_DestReg  in  5  destination register of the MEM instruction.
- ID_BranchOrJR  in  1  ID instruction resolves in ID and reads registers (beq/bne/jr).
- ID_Redirect  in  1  ID has resolved a taken branch or any jump this cycle.
- ControlMux  out  1  1 = pass control bundle, 0 = insert bubble.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register write enable.
- IFIDFlush  out  1  zero IF/ID at the next edge.
- StallActive  out  1  FSM is in STALL (a multi-cycle hold is in progress).

Behaviour:
- Source usage:
  - rt is used when op is one of 0x00, 0x04, 0x05, 0x28, 0x29, 0x2B.
  - rs is used unless op is one of 0x02, 0x03, 0x0F, or op=0x00 with funct one of 0x00, 0x02, 0x03.
  - A source equal to register 0 never matches.
- match(X) = used source register equals X, with X != 0.
- Hazard classes, evaluated combinationally in RUN:
  - H_LU: IDEX_MemRead & match(IDEX_DestReg). Requires 1 bubble.
  - H_BL: ID_BranchOrJR & IDEX_MemRead & match(IDEX_DestReg). Requires LD_BR_STALLS bubbles; takes precedence over H_LU.
  - H_BA: ID_BranchOrJR & IDEX_RegWrite & !IDEX_MemRead & match(IDEX_DestReg). Requires 1 bubble.
  - H_BM: ID_BranchOrJR & EXMEM_MemRead & match(EXMEM_DestReg). Requires 1 bubble.
- Required bubbles N = max over the active classes.
- FSM states: RUN and STALL, with a 2-bit counter Rem.
- RUN:
  - If N >= 1: ControlMux=0, PCWrite=0, IFIDWrite=0, IFIDFlush=0.
  - If N >= 2: Rem <= N-1 and go to STALL.
  - Otherwise stay in RUN; detection repeats next cycle with the advanced pipeline.
  - If N = 0: ControlMux=1, PCWrite=1, IFIDWrite=1, IFIDFlush=ID_Redirect.
- STALL:
  - Outputs held as ControlMux=0, PCWrite=0, IFIDWrite=0, IFIDFlush=0, StallActive=1, independent of the hazard inputs.
  - Rem decrements each cycle; leave for RUN when Rem = 1.
  - STALL therefore lasts exactly N-1 cycles after the detecting cycle.
- Priority: a stall beats a redirect. ID_Redirect is ignored while any bubble is issued, because the branch is not yet resolved with valid operands.
- StallActive=0 in RUN.
- Latency: stall decisions are combinational in the same cycle. Only the hold sequence is registered.
- Reset:
  - Rst_n low forces state=RUN and Rem=0.
  - While Rst_n is low, outputs are forced to ControlMux=1, PCWrite=1, IFIDWrite=1, IFIDFlush=0, StallActive=0 regardless of inputs.
  - Reset asserted mid-STALL aborts the hold immediately.
- After release, the first edge evaluates from RUN.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, add outputs StallCycles[PERF_W-1:0] and FlushCount[PERF_W-1:0].
  - StallCycles increments on every edge with ControlMux=0.
  - FlushCount increments on every edge with IFIDFlush=1.
  - Both reset to 0 on Rst_n low and saturate at all-ones (no wrap).
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Load-use: EX = lw $8 (MemRead=1, Dest=8); ID = add $9,$8,$10 (op 0x00, rs=8) -> exactly 1 cycle of ControlMux=0, PCWrite=0, IFIDWrite=0. Next cycle all 1, StallActive stays 0.
- Branch-after-load, LD_BR_STALLS=2: EX = lw $5; ID = beq $5,$6 with ID_BranchOrJR=1 -> 2 consecutive bubble cycles, StallActive=1 in the second only. Hazard inputs randomized during the second cycle have no effect.
- Branch-after-ALU: EX = add writing $7 (RegWrite=1, MemRead=0); ID = bne $7,$0 -> 1 bubble. Then EX = bubble and ID_Redirect=1 -> IFIDFlush=1 for one cycle, PCWrite=1.
- Register 0 / unused source: EX = lw $0, ID = add using $0 -> no stall. EX = lw $4, ID = sll $2,$4,3 (rs field 4, funct 0x00) -> no stall (rs unused for shift). ID = lui -> no stall.
- Simultaneous stall and redirect: ID_Redirect=1 with H_BM active -> IFIDFlush=0, ControlMux=0.
- Reset: Rst_n driven low in the middle of STALL -> outputs are 1,1,1,0,0 in the same cycle. After release with no hazards, normal flow resumes. With HAZARD_PERF_CNT_EN defined, both counters read 0.
